// File: rtl/sonic_pcs_eth_10g_mac_st_timing_adapter_rl.sv
// Avalon-ST timing adapter: upstream ready latency IN_READY_LATENCY to a
// downstream ready latency of 0, with a small first-word-fall-through FIFO
// that absorbs in-flight beats so downstream backpressure is honoured.
// Optional build macro SONIC_ST_TA_BP_STATS_EN adds bp_cycles / max_occ.
// Optional build macro SONIC_ST_TA_PROTOCOL_CHECK enables simulation-only
// $error reports for overflow and for beats sent without a ready grant.
module sonic_pcs_eth_10g_mac_st_timing_adapter_rl #(
   parameter int DATA_W           = 64,
   parameter int EMPTY_W          = 3,
   parameter int IN_READY_LATENCY = 0,
   parameter int DEPTH            = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_error,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic [EMPTY_W-1:0]       in_empty,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_error,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [EMPTY_W-1:0]       out_empty,
   input  logic                     out_ready,
   output logic                     overflow
`ifdef SONIC_ST_TA_BP_STATS_EN
   ,
   output logic [31:0]              bp_cycles,
   output logic [$clog2(DEPTH):0]   max_occ
`endif
);

   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = (AW > 0) ? AW : 1;
   localparam int CW   = AW + 2;
   localparam int PL_W = DATA_W + EMPTY_W + 3;
   localparam int HW   = (IN_READY_LATENCY > 0) ? IN_READY_LATENCY : 1;

   if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0 ||
       DEPTH < IN_READY_LATENCY + 1) begin : g_bad_depth
      $error("DEPTH must be a power of two >= IN_READY_LATENCY+1");
   end
   if (IN_READY_LATENCY < 0 || IN_READY_LATENCY > 4) begin : g_bad_rl
      $error("IN_READY_LATENCY must be in 0..4");
   end

   logic [PL_W-1:0] mem [DEPTH];
   logic [AW:0]     occ;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   pending;
   logic            full;
   logic            pop;
   logic            push;
   logic            drop;

`ifdef SONIC_ST_TA_PROTOCOL_CHECK
   logic            grant;
`endif

   if (IN_READY_LATENCY == 0) begin : g_rl0
      assign pending = '0;
`ifdef SONIC_ST_TA_PROTOCOL_CHECK
      assign grant = in_ready;
`endif
   end else begin : g_rln
      logic [HW-1:0] rdy_hist;

      // Shift in this cycle's ready grant; bit i is the grant i+1 cycles ago.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) rdy_hist <= '0;
         else       rdy_hist <= HW'({rdy_hist, in_ready});
      end

      // Grants still in flight: each may deliver one beat in a later cycle.
      always_comb begin
         pending = '0;
         for (int i = 0; i < IN_READY_LATENCY; i++)
            pending = pending + CW'(rdy_hist[i]);
      end

`ifdef SONIC_ST_TA_PROTOCOL_CHECK
      assign grant = rdy_hist[HW-1];
`endif
   end

   assign full      = (occ == (AW+1)'(DEPTH));
   assign out_valid = (occ != '0);
   assign pop       = out_valid & out_ready;
   assign push      = in_valid & (~full | pop);
   assign drop      = in_valid & full & ~pop;
   assign in_ready  = (CW'(occ) + pending) < CW'(DEPTH);

   assign {out_data, out_error, out_startofpacket,
           out_endofpacket, out_empty} = mem[rd_ptr];

   // Payload storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {in_data, in_error, in_startofpacket,
                         in_endofpacket, in_empty};
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         if (push && !pop)
            occ <= occ + (AW+1)'(1);
         else if (pop && !push)
            occ <= occ - (AW+1)'(1);
         if (drop)
            overflow <= 1'b1;
      end
   end

`ifdef SONIC_ST_TA_BP_STATS_EN
   // Saturating backpressure counter and occupancy high-water mark.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bp_cycles <= '0;
         max_occ   <= '0;
      end else begin
         if (out_valid && !out_ready && bp_cycles != 32'hFFFF_FFFF)
            bp_cycles <= bp_cycles + 32'd1;
         if (occ > max_occ)
            max_occ <= occ;
      end
   end
`endif

`ifdef SONIC_ST_TA_PROTOCOL_CHECK
   // Report upstream protocol violations as they happen.
   always_ff @(posedge clk) begin
      if (!reset && drop && !overflow)
         $error("st_timing_adapter: beat dropped, FIFO full");
      if (!reset && in_valid && !grant)
         $error("st_timing_adapter: in_valid without ready grant");
   end
`endif

endmodule

// File: tb/tb_sonic_pcs_eth_10g_mac_st_timing_adapter_rl.sv
// Bench for sonic_pcs_eth_10g_mac_st_timing_adapter_rl: one RL=0 and one
// RL=2 instance share stimulus; a queue model of the FIFO predicts outputs.
module tb_sonic_pcs_eth_10g_mac_st_timing_adapter_rl;

   localparam int DW = 64;
   localparam int EW = 3;
   localparam int D  = 4;
   typedef logic [DW+EW+2:0] pl_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_error = 1'b0;
   logic          in_sop = 1'b0;
   logic          in_eop = 1'b0;
   logic [EW-1:0] in_empty = '0;
   logic          out_ready = 1'b0;

   logic          ir0, ov0, oe0, os0, oo0, of0;
   logic [DW-1:0] od0;
   logic [EW-1:0] om0;
   logic          ir2, ov2, oe2, os2, oo2, of2;
   logic [DW-1:0] od2;
   logic [EW-1:0] om2;
`ifdef SONIC_ST_TA_BP_STATS_EN
   logic [31:0]   bp0, bp2;
   logic [2:0]    mo0, mo2;
`endif

   bit            sel2;
   logic          x_ir, x_ov, x_of;
   pl_t           x_pl;

   pl_t           q[$];
   bit            gh[$];
   int            rl;
   bit            m_ovf;
   int            n_cmp;
   int            n_bad;

   always #5 clk = ~clk;

   sonic_pcs_eth_10g_mac_st_timing_adapter_rl #(
      .DATA_W(DW), .EMPTY_W(EW), .IN_READY_LATENCY(0), .DEPTH(D)
   ) u_rl0 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop),
      .in_empty(in_empty), .in_ready(ir0),
      .out_valid(ov0), .out_data(od0), .out_error(oe0),
      .out_startofpacket(os0), .out_endofpacket(oo0),
      .out_empty(om0), .out_ready(out_ready), .overflow(of0)
`ifdef SONIC_ST_TA_BP_STATS_EN
      , .bp_cycles(bp0), .max_occ(mo0)
`endif
   );

   sonic_pcs_eth_10g_mac_st_timing_adapter_rl #(
      .DATA_W(DW), .EMPTY_W(EW), .IN_READY_LATENCY(2), .DEPTH(D)
   ) u_rl2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop),
      .in_empty(in_empty), .in_ready(ir2),
      .out_valid(ov2), .out_data(od2), .out_error(oe2),
      .out_startofpacket(os2), .out_endofpacket(oo2),
      .out_empty(om2), .out_ready(out_ready), .overflow(of2)
`ifdef SONIC_ST_TA_BP_STATS_EN
      , .bp_cycles(bp2), .max_occ(mo2)
`endif
   );

   always_comb begin
      x_ir = sel2 ? ir2 : ir0;
      x_ov = sel2 ? ov2 : ov0;
      x_of = sel2 ? of2 : of0;
      x_pl = sel2 ? {od2, oe2, os2, oo2, om2} : {od0, oe0, os0, oo0, om0};
   end

   function automatic pl_t rnd_pl();
      return {$urandom(), $urandom(), 6'($urandom())};
   endfunction

   // Spec rule: ready when stored beats plus outstanding grants fit.
   function automatic bit m_ready();
      int p = 0;
      foreach (gh[i]) p += int'(gh[i]);
      return (q.size() + p) < D;
   endfunction

   // Upstream may send now only if ready was granted rl cycles ago.
   function automatic bit m_allowed();
      if (rl == 0) return m_ready();
      return (gh.size() == rl) && gh[0];
   endfunction

   // Drive one cycle of inputs, advance the model, land on the next negedge.
   task automatic step(input bit v, input pl_t p, input bit ordy);
      bit mr;
      bit pop;
      in_valid = v;
      {in_data, in_error, in_sop, in_eop, in_empty} = p;
      out_ready = ordy;
      mr  = m_ready();
      pop = (q.size() != 0) && ordy;
      if (pop) void'(q.pop_front());
      if (v) begin
         if (q.size() < D) q.push_back(p);
         else m_ovf = 1'b1;
      end
      if (rl > 0) begin
         gh.push_back(mr);
         if (gh.size() > rl) void'(gh.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int new_rl);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      gh.delete();
      m_ovf = 1'b0;
      rl    = new_rl;
      sel2  = (new_rl == 2);
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if (ov0 !== 1'b0 || ir0 !== 1'b1 || of0 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rl0: got v/r/o=%b%b%b want 010", ov0, ir0, of0);
      end
      n_cmp++;
      if (ov2 !== 1'b0 || ir2 !== 1'b1 || of2 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rl2: got v/r/o=%b%b%b want 010", ov2, ir2, of2);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      pl_t p;
      do_reset(0);
      for (int i = 0; i < 8; i++) begin
         p = rnd_pl();
         p[5:0] = {1'b0, i == 0, i == 7, (i == 7) ? 3'd3 : 3'd0};
         step(1'b1, p, 1'b1);
         n_cmp++;
         if (x_ov !== 1'b1 || x_pl !== p) begin
            n_bad++;
            $display("FAIL b2b_beat%0d: got v=%b %h want v=1 %h", i, x_ov, x_pl, p);
         end
         n_cmp++;
         if (x_ir !== 1'b1 || x_of !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_flags%0d: got r/o=%b%b want 10", i, x_ir, x_of);
         end
      end
      step(1'b0, '0, 1'b1);
      n_cmp++;
      if (x_ov !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle: got out_valid=%b want 0", x_ov);
      end
   endtask

   task automatic test_backpressure();
      int cnt = 0;
      do_reset(2);
      for (int c = 0; c < 10; c++) begin
         step(m_allowed(), rnd_pl(), 1'b0);
         n_cmp++;
         if (x_ir !== m_ready() || x_ov !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL bp_fill%0d: got r/v=%b%b want %b%b",
                     c, x_ir, x_ov, m_ready(), q.size() != 0);
         end
      end
      n_cmp++;
      if (x_ir !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_full_ready: got %b want 0", x_ir);
      end
      for (int g = 0; g < 8 && x_ov === 1'b1; g++) begin
         n_cmp++;
         if (q.size() == 0 || x_pl !== q[0]) begin
            n_bad++;
            $display("FAIL bp_drain%0d: got %h want model head", cnt, x_pl);
         end
         cnt++;
         step(1'b0, '0, 1'b1);
      end
      n_cmp++;
      if (cnt != 4 || x_ir !== 1'b1 || x_of !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_count: got %0d beats r=%b o=%b want 4 1 0",
                  cnt, x_ir, x_of);
      end
   endtask

   task automatic test_scoreboard();
      int pushes = 0;
      bit v;
      do_reset(2);
      for (int c = 0; c < 6000 && (pushes < 1000 || q.size() != 0); c++) begin
         v = m_allowed() && pushes < 1000 && ($urandom_range(3) != 0);
         if (v) pushes++;
         step(v, rnd_pl(), (pushes >= 1000) || (c % 2 == 0));
         n_cmp++;
         if (x_ov !== (q.size() != 0) || (q.size() != 0 && x_pl !== q[0])) begin
            n_bad++;
            $display("FAIL sb_out c%0d: got v=%b %h want v=%b",
                     c, x_ov, x_pl, q.size() != 0);
         end
         n_cmp++;
         if (x_ir !== m_ready() || x_of !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_flags c%0d: got r/o=%b%b want %b0",
                     c, x_ir, x_of, m_ready());
         end
      end
      n_cmp++;
      if (pushes != 1000 || x_ov !== 1'b0) begin
         n_bad++;
         $display("FAIL sb_done: got %0d beats v=%b want 1000 0", pushes, x_ov);
      end
   endtask

   task automatic test_overflow();
      pl_t extra;
      int cnt = 0;
      do_reset(0);
      for (int i = 0; i < 4; i++) step(1'b1, rnd_pl(), 1'b0);
      n_cmp++;
      if (x_ir !== 1'b0 || x_of !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_full: got r/o=%b%b want 00", x_ir, x_of);
      end
      extra = rnd_pl();
      step(1'b1, extra, 1'b0);
      n_cmp++;
      if (x_of !== 1'b1 || x_ir !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_set: got o/r=%b%b want 10", x_of, x_ir);
      end
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
      n_cmp++;
      if (x_of !== 1'b1 || x_ov !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_hold: got o/v=%b%b want 11", x_of, x_ov);
      end
      for (int g = 0; g < 8 && x_ov === 1'b1; g++) begin
         n_cmp++;
         if (q.size() == 0 || x_pl !== q[0] || x_pl === extra) begin
            n_bad++;
            $display("FAIL ovf_drain%0d: got %h want model head", cnt, x_pl);
         end
         cnt++;
         step(1'b0, '0, 1'b1);
      end
      n_cmp++;
      if (cnt != 4 || x_of !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_count: got %0d beats o=%b want 4 1", cnt, x_of);
      end
   endtask

   task automatic test_full_push_pop();
      pl_t nb;
      int cnt = 0;
      do_reset(0);
      for (int i = 0; i < 4; i++) step(1'b1, rnd_pl(), 1'b0);
      nb = rnd_pl();
      step(1'b1, nb, 1'b1);
      n_cmp++;
      if (x_of !== 1'b0 || x_ir !== 1'b0 || x_ov !== 1'b1 || x_pl !== q[0]) begin
         n_bad++;
         $display("FAIL fpp_cycle: got o/r/v=%b%b%b %h want 001 %h",
                  x_of, x_ir, x_ov, x_pl, q[0]);
      end
      for (int g = 0; g < 8 && x_ov === 1'b1; g++) begin
         n_cmp++;
         if (q.size() == 0 || x_pl !== q[0]) begin
            n_bad++;
            $display("FAIL fpp_drain%0d: got %h want model head", cnt, x_pl);
         end
         cnt++;
         step(1'b0, '0, 1'b1);
      end
      n_cmp++;
      if (cnt != 4 || x_of !== 1'b0) begin
         n_bad++;
         $display("FAIL fpp_count: got %0d beats o=%b want 4 0", cnt, x_of);
      end
   endtask

   task automatic test_reset_mid();
      pl_t p;
      int sent = 0;
      do_reset(2);
      for (int c = 0; c < 20 && q.size() < 3; c++) begin
         p = rnd_pl();
         p[4] = (q.size() == 0);
         p[3] = 1'b0;
         step(m_allowed(), p, 1'b0);
      end
      n_cmp++;
      if (x_ov !== 1'b1 || x_ir !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_pre: got v/r=%b%b want 10", x_ov, x_ir);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (ov2 !== 1'b0 || ir2 !== 1'b1 || of2 !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_async: got v/r/o=%b%b%b want 010", ov2, ir2, of2);
      end
`ifdef SONIC_ST_TA_BP_STATS_EN
      n_cmp++;
      if (bp2 !== 32'd0 || mo2 !== 3'd0) begin
         n_bad++;
         $display("FAIL rmid_stats: got bp=%0d max=%0d want 0 0", bp2, mo2);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      gh.delete();
      m_ovf = 1'b0;
      for (int c = 0; c < 30; c++) begin
         bit v = m_allowed() && sent < 4;
         p = rnd_pl();
         p[4] = (sent == 0);
         p[3] = (sent == 3);
         if (v) sent++;
         step(v, p, 1'b1);
         n_cmp++;
         if (x_ov !== (q.size() != 0) || (q.size() != 0 && x_pl !== q[0])
             || x_of !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_pkt c%0d: got v=%b o=%b %h", c, x_ov, x_of, x_pl);
         end
      end
      n_cmp++;
      if (sent != 4 || x_ov !== 1'b0 || x_ir !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_done: got %0d sent v/r=%b%b want 4 01",
                  sent, x_ov, x_ir);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      sel2  = 1'b0;
      rl    = 0;
      m_ovf = 1'b0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_scoreboard();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
